// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types for the multi-cycle control sequencer: state encoding,
// instruction class codes, default field widths and the registered strobe bundle.
package ctrl_pkg;

    localparam int ALU_OP_W_DEF   = 4;
    localparam int SHIFT_OP_W_DEF = 3;

    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_LDR = 2'b01;
    localparam logic [1:0] CLS_STR = 2'b10;
    localparam logic [1:0] CLS_B   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC     = 4'd3,
        S_WB       = 4'd4,
        S_MEM_REQ  = 4'd5,
        S_MEM_WAIT = 4'd6,
        S_MEM_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_FAULT    = 4'd9
    } state_t;

    typedef struct packed {
        logic write_pc;
        logic write_ir;
        logic write_reg;
        logic pc_sel;
        logic la;
        logic lb;
        logic lc;
        logic lf;
        logic mem_req;
        logic mem_we;
        logic reg_src;
        logic fault;
    } strobes_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Data-memory request/acknowledge handshake between the sequencer and the memory port.
interface multicycle_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Wait-state counter for MEM_WAIT: cleared by load, counts while enabled,
// flags timeout at WAIT_MAX and saturates there so it can never wrap.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic timeout
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= '0;
        else if (en && !timeout)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign timeout = (cnt_q == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for DP/LDR/STR/B with memory wait-state timeout.
// Optional CTRL_PSR_WRITE_EN adds write_cpsr/write_spsr strobes.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W   = ALU_OP_W_DEF,
    parameter int SHIFT_OP_W = SHIFT_OP_W_DEF,
    parameter int WAIT_MAX   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ir_valid,
    input  logic [1:0]              instr_class,
    input  logic                    rm_imm_s,
    input  logic [1:0]              rs_imm_s,
    input  logic [SHIFT_OP_W-1:0]   shift_op,
    input  logic [ALU_OP_W-1:0]     alu_op,
    input  logic                    s_bit,
    input  logic                    cond_fail,
    multicycle_ctrl_fsm_if.master   mem,
    output logic                    write_pc,
    output logic                    write_ir,
    output logic                    write_reg,
    output logic                    pc_sel,
    output logic                    la,
    output logic                    lb,
    output logic                    lc,
    output logic                    lf,
    output logic                    reg_src,
    output logic                    rm_imm_s_ctrl,
    output logic [1:0]              rs_imm_s_ctrl,
    output logic [SHIFT_OP_W-1:0]   shift_op_ctrl,
    output logic [ALU_OP_W-1:0]     alu_op_ctrl,
    output logic                    s_ctrl,
    output logic                    fault
`ifdef CTRL_PSR_WRITE_EN
    ,
    output logic                    write_cpsr,
    output logic                    write_spsr
`endif
);

    state_t   state_q, state_d;
    strobes_t out_q, out_d;
    logic     tmr_load, tmr_en, tmr_timeout;

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .timeout (tmr_timeout)
    );

    assign tmr_load = (state_q == S_MEM_REQ);
    assign tmr_en   = (state_q == S_MEM_WAIT);

    // Next state, then strobes decoded from that next state so they line up
    // with the state register after the edge.
    always_comb begin
        state_d = state_q;
        out_d   = '0;

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (ir_valid) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (cond_fail)
                    state_d = S_FETCH;
                else begin
                    case (instr_class)
                        CLS_DP:  state_d = S_WB;
                        CLS_LDR: state_d = S_MEM_REQ;
                        CLS_STR: state_d = S_MEM_REQ;
                        default: state_d = S_BRANCH;
                    endcase
                end
            end
            S_WB:      state_d = S_FETCH;
            S_MEM_REQ: state_d = S_MEM_WAIT;
            // The registered mem_we tells a store (back to FETCH) from a load.
            S_MEM_WAIT: begin
                if (mem.mem_ack)
                    state_d = out_q.mem_we ? S_FETCH : S_MEM_WB;
                else if (tmr_timeout)
                    state_d = S_FAULT;
            end
            S_MEM_WB:  state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_FAULT:   state_d = S_FAULT;
            default:   state_d = S_IDLE;
        endcase

        case (state_d)
            S_FETCH: begin
                out_d.write_pc = 1'b1;
                out_d.write_ir = ir_valid;
            end
            S_DECODE: begin
                out_d.la = 1'b1;
                out_d.lb = 1'b1;
                out_d.lc = 1'b1;
            end
            S_EXEC:    out_d.lf = s_bit;
            S_WB:      out_d.write_reg = 1'b1;
            S_MEM_REQ: begin
                out_d.mem_req = 1'b1;
                out_d.mem_we  = (instr_class == CLS_STR);
            end
            S_MEM_WAIT: begin
                out_d.mem_req = 1'b1;
                out_d.mem_we  = out_q.mem_we;
            end
            S_MEM_WB: begin
                out_d.write_reg = 1'b1;
                out_d.reg_src   = 1'b1;
            end
            S_BRANCH: begin
                out_d.write_pc = 1'b1;
                out_d.pc_sel   = 1'b1;
            end
            S_FAULT:  out_d.fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Decode fields are captured on entry to EXEC and held until the next EXEC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rm_imm_s_ctrl <= 1'b0;
            rs_imm_s_ctrl <= '0;
            shift_op_ctrl <= '0;
            alu_op_ctrl   <= '0;
            s_ctrl        <= 1'b0;
        end else if (state_d == S_EXEC) begin
            rm_imm_s_ctrl <= rm_imm_s;
            rs_imm_s_ctrl <= rs_imm_s;
            shift_op_ctrl <= shift_op;
            alu_op_ctrl   <= alu_op;
            s_ctrl        <= s_bit && (instr_class == CLS_DP);
        end
    end

    assign write_pc    = out_q.write_pc;
    assign write_ir    = out_q.write_ir;
    assign write_reg   = out_q.write_reg;
    assign pc_sel      = out_q.pc_sel;
    assign la          = out_q.la;
    assign lb          = out_q.lb;
    assign lc          = out_q.lc;
    assign lf          = out_q.lf;
    assign reg_src     = out_q.reg_src;
    assign fault       = out_q.fault;
    assign mem.mem_req = out_q.mem_req;
    assign mem.mem_we  = out_q.mem_we;

`ifdef CTRL_PSR_WRITE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            write_cpsr <= 1'b0;
        else
            write_cpsr <= (state_d == S_WB) && s_ctrl;
    end

    // SPSR writes are reserved for a future exception model.
    assign write_spsr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: each instruction class, skip, wait states,
// ack at timeout boundary, reset mid-access and sticky fault.
module tb_multicycle_ctrl_fsm;
    import ctrl_pkg::*;

    // Strobe vector order: write_pc write_ir write_reg pc_sel la lb lc lf mem_req mem_we reg_src fault
    localparam logic [11:0] ST_ZERO   = 12'h000;
    localparam logic [11:0] ST_FETCH  = 12'h800;
    localparam logic [11:0] ST_FETCHI = 12'hC00;
    localparam logic [11:0] ST_DECODE = 12'h0E0;
    localparam logic [11:0] ST_EXECF  = 12'h010;
    localparam logic [11:0] ST_WB     = 12'h200;
    localparam logic [11:0] ST_LDREQ  = 12'h008;
    localparam logic [11:0] ST_STREQ  = 12'h00C;
    localparam logic [11:0] ST_MEMWB  = 12'h202;
    localparam logic [11:0] ST_BRANCH = 12'h900;
    localparam logic [11:0] ST_FAULT  = 12'h001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ir_valid = 1'b0;
    logic [1:0] instr_class = 2'b00;
    logic       rm_imm_s = 1'b0;
    logic [1:0] rs_imm_s = 2'b00;
    logic [2:0] shift_op = 3'd0;
    logic [3:0] alu_op = 4'd0;
    logic       s_bit = 1'b0;
    logic       cond_fail = 1'b0;
    logic       write_pc, write_ir, write_reg, pc_sel, la, lb, lc, lf, reg_src, fault;
    logic       rm_imm_s_ctrl, s_ctrl;
    logic [1:0] rs_imm_s_ctrl;
    logic [2:0] shift_op_ctrl;
    logic [3:0] alu_op_ctrl;
`ifdef CTRL_PSR_WRITE_EN
    logic       write_cpsr, write_spsr;
`endif
    logic [11:0] strb;
    int errors = 0;
    int checks = 0;

    multicycle_ctrl_fsm_if mem_if();

    multicycle_ctrl_fsm #(.ALU_OP_W(4), .SHIFT_OP_W(3), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .ir_valid(ir_valid), .instr_class(instr_class),
        .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .shift_op(shift_op), .alu_op(alu_op),
        .s_bit(s_bit), .cond_fail(cond_fail), .mem(mem_if),
        .write_pc(write_pc), .write_ir(write_ir), .write_reg(write_reg), .pc_sel(pc_sel),
        .la(la), .lb(lb), .lc(lc), .lf(lf), .reg_src(reg_src),
        .rm_imm_s_ctrl(rm_imm_s_ctrl), .rs_imm_s_ctrl(rs_imm_s_ctrl),
        .shift_op_ctrl(shift_op_ctrl), .alu_op_ctrl(alu_op_ctrl), .s_ctrl(s_ctrl),
        .fault(fault)
`ifdef CTRL_PSR_WRITE_EN
        , .write_cpsr(write_cpsr), .write_spsr(write_spsr)
`endif
    );

    always #5 clk = ~clk;

    assign strb = {write_pc, write_ir, write_reg, pc_sel, la, lb, lc, lf,
                   mem_if.mem_req, mem_if.mem_we, reg_src, fault};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mem_if.mem_ack = 1'b0;
        rst = 1'b0;
        tick(); tick();
        checks++; if (strb !== ST_ZERO) begin errors++; $display("FAIL reset_strobes: got %03h want %03h", strb, ST_ZERO); end
        checks++; if ({rm_imm_s_ctrl, rs_imm_s_ctrl, shift_op_ctrl, alu_op_ctrl, s_ctrl} !== 11'd0) begin
            errors++; $display("FAIL reset_ctrl_fields: got %03h want 000", {rm_imm_s_ctrl, rs_imm_s_ctrl, shift_op_ctrl, alu_op_ctrl, s_ctrl}); end
        rst = 1'b1;
        #1;
        checks++; if (strb !== ST_ZERO) begin errors++; $display("FAIL idle_after_release: got %03h want %03h", strb, ST_ZERO); end
        tick();
        checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL first_fetch: got %03h want %03h", strb, ST_FETCH); end
    endtask

    task automatic test_fetch_hold();
        ir_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL fetch_hold[%0d]: got %03h want %03h", i, strb, ST_FETCH); end
        end
    endtask

    task automatic test_dp();
        instr_class = CLS_DP; cond_fail = 1'b0; s_bit = 1'b1; alu_op = 4'h4;
        shift_op = 3'd5; rm_imm_s = 1'b1; rs_imm_s = 2'b10; ir_valid = 1'b1;
        tick();
        checks++; if (strb !== ST_DECODE) begin errors++; $display("FAIL dp_decode: got %03h want %03h", strb, ST_DECODE); end
        ir_valid = 1'b0;
        tick();
        checks++; if (strb !== ST_EXECF) begin errors++; $display("FAIL dp_exec: got %03h want %03h", strb, ST_EXECF); end
        checks++; if ({rm_imm_s_ctrl, rs_imm_s_ctrl, shift_op_ctrl, alu_op_ctrl, s_ctrl} !== {1'b1, 2'b10, 3'd5, 4'h4, 1'b1}) begin
            errors++; $display("FAIL dp_ctrl_fields: got %03h want %03h", {rm_imm_s_ctrl, rs_imm_s_ctrl, shift_op_ctrl, alu_op_ctrl, s_ctrl}, {1'b1, 2'b10, 3'd5, 4'h4, 1'b1}); end
        alu_op = 4'h9;
        tick();
        checks++; if (strb !== ST_WB) begin errors++; $display("FAIL dp_wb: got %03h want %03h", strb, ST_WB); end
`ifdef CTRL_PSR_WRITE_EN
        checks++; if ({write_cpsr, write_spsr} !== 2'b10) begin errors++; $display("FAIL dp_psr_wb: got %b want 10", {write_cpsr, write_spsr}); end
`endif
        tick();
        checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL dp_refetch: got %03h want %03h", strb, ST_FETCH); end
        checks++; if (alu_op_ctrl !== 4'h4) begin errors++; $display("FAIL dp_alu_held: got %0h want 4", alu_op_ctrl); end
`ifdef CTRL_PSR_WRITE_EN
        checks++; if (write_cpsr !== 1'b0) begin errors++; $display("FAIL dp_cpsr_pulse: got %b want 0", write_cpsr); end
`endif
    endtask

    task automatic test_cond_fail();
        s_bit = 1'b0;
        cond_fail = 1'b1;
        for (int c = 0; c < 4; c++) begin
            instr_class = 2'(c);
            ir_valid = 1'b1;
            tick();
            checks++; if (strb !== ST_DECODE) begin errors++; $display("FAIL skip_decode[%0d]: got %03h want %03h", c, strb, ST_DECODE); end
            ir_valid = 1'b0;
            tick();
            checks++; if (strb !== ST_ZERO) begin errors++; $display("FAIL skip_exec[%0d]: got %03h want %03h", c, strb, ST_ZERO); end
            tick();
            checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL skip_refetch[%0d]: got %03h want %03h", c, strb, ST_FETCH); end
        end
        cond_fail = 1'b0;
    endtask

    task automatic test_ldr();
        instr_class = CLS_LDR; s_bit = 1'b1; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        mem_if.mem_ack = 1'b1;  // early ack must be ignored
        tick();
        checks++; if (s_ctrl !== 1'b0) begin errors++; $display("FAIL ldr_s_forced: got %b want 0", s_ctrl); end
        checks++; if ({mem_if.mem_req, write_reg} !== 2'b00) begin errors++; $display("FAIL ldr_exec_idle_bus: got %b want 00", {mem_if.mem_req, write_reg}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (strb !== ST_LDREQ) begin errors++; $display("FAIL ldr_req[%0d]: got %03h want %03h", i, strb, ST_LDREQ); end
            if (i == 0) mem_if.mem_ack = 1'b0;
            if (i == 3) mem_if.mem_ack = 1'b1;
        end
        tick();
        mem_if.mem_ack = 1'b0;
        checks++; if (strb !== ST_MEMWB) begin errors++; $display("FAIL ldr_memwb: got %03h want %03h", strb, ST_MEMWB); end
        tick();
        checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL ldr_refetch: got %03h want %03h", strb, ST_FETCH); end
    endtask

    task automatic test_str();
        instr_class = CLS_STR; s_bit = 1'b1; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick();
        checks++; if (s_ctrl !== 1'b0) begin errors++; $display("FAIL str_s_forced: got %b want 0", s_ctrl); end
        tick();
        checks++; if (strb !== ST_STREQ) begin errors++; $display("FAIL str_req: got %03h want %03h", strb, ST_STREQ); end
        mem_if.mem_ack = 1'b1;
        tick();
        checks++; if (strb !== ST_STREQ) begin errors++; $display("FAIL str_wait: got %03h want %03h", strb, ST_STREQ); end
        tick();
        mem_if.mem_ack = 1'b0;
        checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL str_refetch: got %03h want %03h", strb, ST_FETCH); end
    endtask

    task automatic test_back_to_back();
        instr_class = CLS_B; s_bit = 1'b0; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick();
        tick();
        checks++; if (strb !== ST_BRANCH) begin errors++; $display("FAIL b_branch: got %03h want %03h", strb, ST_BRANCH); end
        instr_class = CLS_DP; alu_op = 4'h7; ir_valid = 1'b1;
        tick();
        checks++; if (strb !== ST_FETCHI) begin errors++; $display("FAIL b2b_fetch_ir: got %03h want %03h", strb, ST_FETCHI); end
        tick();
        checks++; if (strb !== ST_DECODE) begin errors++; $display("FAIL b2b_decode: got %03h want %03h", strb, ST_DECODE); end
        ir_valid = 1'b0;
        tick();
        checks++; if ({strb, alu_op_ctrl, s_ctrl} !== {ST_ZERO, 4'h7, 1'b0}) begin
            errors++; $display("FAIL b2b_exec: got %04h want %04h", {strb, alu_op_ctrl, s_ctrl}, {ST_ZERO, 4'h7, 1'b0}); end
        tick();
        checks++; if (strb !== ST_WB) begin errors++; $display("FAIL b2b_wb: got %03h want %03h", strb, ST_WB); end
`ifdef CTRL_PSR_WRITE_EN
        checks++; if ({write_cpsr, write_spsr} !== 2'b00) begin errors++; $display("FAIL b2b_psr_quiet: got %b want 00", {write_cpsr, write_spsr}); end
`endif
        tick();
        checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL b2b_refetch: got %03h want %03h", strb, ST_FETCH); end
    endtask

    task automatic test_ack_at_timeout();
        instr_class = CLS_LDR; s_bit = 1'b0; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick();
        for (int i = 0; i <= 16; i++) begin
            tick();
            checks++; if (strb !== ST_LDREQ) begin errors++; $display("FAIL ackto_wait[%0d]: got %03h want %03h", i, strb, ST_LDREQ); end
            if (i == 16) mem_if.mem_ack = 1'b1;
        end
        tick();
        mem_if.mem_ack = 1'b0;
        checks++; if (strb !== ST_MEMWB) begin errors++; $display("FAIL ackto_wins: got %03h want %03h", strb, ST_MEMWB); end
        tick();
        checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL ackto_refetch: got %03h want %03h", strb, ST_FETCH); end
    endtask

    task automatic test_rst_mid_access();
        instr_class = CLS_LDR; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        repeat (4) tick();
        checks++; if (strb !== ST_LDREQ) begin errors++; $display("FAIL rstmid_inwait: got %03h want %03h", strb, ST_LDREQ); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_async_drop: got %b want 0", mem_if.mem_req); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (strb !== ST_ZERO) begin errors++; $display("FAIL rstmid_idle: got %03h want %03h", strb, ST_ZERO); end
        tick();
        checks++; if (strb !== ST_FETCH) begin errors++; $display("FAIL rstmid_fetch: got %03h want %03h", strb, ST_FETCH); end
    endtask

    task automatic test_str_timeout();
        instr_class = CLS_STR; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick();
        for (int i = 0; i <= 16; i++) begin
            tick();
            checks++; if (strb !== ST_STREQ) begin errors++; $display("FAIL to_wait[%0d]: got %03h want %03h", i, strb, ST_STREQ); end
        end
        tick();
        checks++; if (strb !== ST_FAULT) begin errors++; $display("FAIL to_fault: got %03h want %03h", strb, ST_FAULT); end
        ir_valid = 1'b1;
        mem_if.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (strb !== ST_FAULT) begin errors++; $display("FAIL to_sticky[%0d]: got %03h want %03h", i, strb, ST_FAULT); end
        end
        mem_if.mem_ack = 1'b0;
        ir_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (strb !== ST_ZERO) begin errors++; $display("FAIL to_reset_clears: got %03h want %03h", strb, ST_ZERO); end
    endtask

    initial begin
        test_reset();
        test_fetch_hold();
        test_dp();
        test_cond_fail();
        test_ldr();
        test_str();
        test_back_to_back();
        test_ack_at_timeout();
        test_rst_mid_access();
        test_str_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
